// File: rtl/subtractor_seq.sv
// rtl/subtractor_seq.sv - chunk-serial unsigned subtractor with valid/ready handshake (optional SUBTRACTOR_SAT_EN saturation)
module subtractor_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;
    logic [WIDTH-1:0]  d_q;
    logic              carry_q;
    logic              borrow_q;
    logic [CW-1:0]     k_q;

    logic [CHUNK-1:0]  x_chunk;
    logic [CHUNK-1:0]  y_inv;
    logic [CHUNK:0]    sum0;
    logic [CHUNK:0]    sum1;
    logic [CHUNK:0]    sum_sel;
    logic              last_chunk;
    logic              accept;

    // Conditional-sum chunk adder: both carry-in cases formed, registered carry picks one.
    always_comb begin
        x_chunk    = x_q[k_q*CHUNK +: CHUNK];
        y_inv      = ~y_q[k_q*CHUNK +: CHUNK];
        sum0       = {1'b0, x_chunk} + {1'b0, y_inv};
        sum1       = {1'b0, x_chunk} + {1'b0, y_inv} + {{CHUNK{1'b0}}, 1'b1};
        sum_sel    = carry_q ? sum1 : sum0;
        last_chunk = (k_q == CW'(NCHUNK - 1));
        accept     = in_valid && (state_q == IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and one chunk of x + ~y + carry per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            d_q      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            k_q      <= '0;
        end else if (accept) begin
            x_q      <= x;
            y_q      <= y;
            k_q      <= '0;
            carry_q  <= 1'b1;
            borrow_q <= 1'b0;
        end else if (state_q == BUSY) begin
            d_q[k_q*CHUNK +: CHUNK] <= sum_sel[CHUNK-1:0];
            carry_q                 <= sum_sel[CHUNK];
            k_q                     <= last_chunk ? '0 : k_q + CW'(1);
            if (last_chunk) begin
                borrow_q <= ~sum_sel[CHUNK];
            end
        end
    end

    // Handshake flags follow the state; result optionally clamps to zero on underflow.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        borrow    = borrow_q;
`ifdef SUBTRACTOR_SAT_EN
        d         = borrow_q ? '0 : d_q;
`else
        d         = d_q;
`endif
    end

endmodule
